// File: rtl/pic_pkg.sv
// pic_pkg: shared definitions for the PIC datapath.
//   - OCW2 {R, SL, EOI} command encodings.
//   - Cyclic rotate helpers and a lowest-set-bit isolator. They work on a
//     32-bit container, because 32 is the largest supported level count.
//     The active width is passed in as 'levels'; bits at and above 'levels'
//     are returned as zero.
package pic_pkg;

    localparam int unsigned MAX_LEVELS = 32;

    // OCW2 {R, SL, EOI}
    localparam logic [2:0] ROT_AEOI_CLR    = 3'b000;
    localparam logic [2:0] EOI_NONSPEC     = 3'b001;
    localparam logic [2:0] EOI_NOP         = 3'b010;
    localparam logic [2:0] EOI_SPEC        = 3'b011;
    localparam logic [2:0] ROT_AEOI_SET    = 3'b100;
    localparam logic [2:0] EOI_ROT_NONSPEC = 3'b101;
    localparam logic [2:0] SET_PRIORITY    = 3'b110;
    localparam logic [2:0] EOI_ROT_SPEC    = 3'b111;

    // Result bit i takes input bit (i + amt) mod levels. amt must be < levels.
    function automatic logic [MAX_LEVELS-1:0] rotate_right(
        input logic [MAX_LEVELS-1:0] vec,
        input int unsigned           amt,
        input int unsigned           levels
    );
        logic [MAX_LEVELS-1:0] r;
        int unsigned           idx;
        r = '0;
        for (int unsigned i = 0; i < MAX_LEVELS; i++) begin
            if (i < levels) begin
                idx = i + amt;
                if (idx >= levels) idx = idx - levels;
                r[i] = vec[idx[4:0]];
            end
        end
        return r;
    endfunction

    // This is the inverse of rotate_right. Result bit (i + amt) mod levels
    // takes input bit i.
    function automatic logic [MAX_LEVELS-1:0] rotate_left(
        input logic [MAX_LEVELS-1:0] vec,
        input int unsigned           amt,
        input int unsigned           levels
    );
        logic [MAX_LEVELS-1:0] r;
        int unsigned           idx;
        r = '0;
        for (int unsigned i = 0; i < MAX_LEVELS; i++) begin
            if (i < levels) begin
                idx = i + amt;
                if (idx >= levels) idx = idx - levels;
                r[idx[4:0]] = vec[i];
            end
        end
        return r;
    endfunction

    // Keeps only the lowest set bit. The two's-complement trick gives zero
    // when the input is zero.
    function automatic logic [MAX_LEVELS-1:0] resolve_lowest(
        input logic [MAX_LEVELS-1:0] vec
    );
        return vec & (~vec + 32'd1);
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// priority_resolver: picks the highest-priority set bit of a request vector
// under cyclic priority. The level just after 'rotate' is the most important,
// and 'rotate' itself is the least important. The IRR side uses this block too.
// Ports:
//   masked  in  LEVELS : candidate vector (ISR or IRR after masking)
//   rotate  in  PRIO_W : index of the lowest-priority level
//   highest out LEVELS : one-hot winner, or 0 when masked is 0
module priority_resolver
    import pic_pkg::*;
#(
    parameter int LEVELS = 8,
    parameter int PRIO_W = $clog2(LEVELS)
) (
    input  logic [LEVELS-1:0] masked,
    input  logic [PRIO_W-1:0] rotate,
    output logic [LEVELS-1:0] highest
);

    int unsigned start;

    // Rotate so that the top-priority level lands on bit 0. Then take the
    // lowest set bit and rotate the result back into place.
    always_comb begin
        start = 32'(rotate) + 32'd1;
        if (start >= LEVELS) start = 0;
        highest = LEVELS'(rotate_left(
                      resolve_lowest(rotate_right(32'(masked), start, LEVELS)),
                      start, LEVELS));
    end

endmodule

// File: rtl/in_service_ctrl.sv
// in_service_ctrl: PIC in-service register. It handles these actions:
//   - it latches the acknowledged level on the first INTA;
//   - it runs the OCW2 EOI and rotation commands;
//   - it runs auto-EOI at the end of the INTA sequence.
// It keeps the priority rotation state and publishes the highest unmasked
// in-service level.
// Ports:
//   clock, reset (sync, active-high)
//   latch_in_service, interrupt      : set ISR bits from the acknowledged level
//   end_of_ack, auto_eoi_mode        : auto-EOI trigger and enable
//   eoi_valid, eoi_cmd, eoi_level    : OCW2 strobe, {R,SL,EOI}, L field
//   special_mask_mode, interrupt_special_mask : SMM view of the ISR
//   in_service_register, highest_level_in_service, priority_rotate,
//   rotate_in_aeoi                   : outputs
module in_service_ctrl
    import pic_pkg::*;
#(
    parameter int LEVELS = 8,
    parameter int PRIO_W = $clog2(LEVELS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              latch_in_service,
    input  logic [LEVELS-1:0] interrupt,
    input  logic              end_of_ack,
    input  logic              auto_eoi_mode,
    input  logic              eoi_valid,
    input  logic [2:0]        eoi_cmd,
    input  logic [PRIO_W-1:0] eoi_level,
    input  logic              special_mask_mode,
    input  logic [LEVELS-1:0] interrupt_special_mask,
    output logic [LEVELS-1:0] in_service_register,
    output logic [LEVELS-1:0] highest_level_in_service,
    output logic [PRIO_W-1:0] priority_rotate,
    output logic              rotate_in_aeoi
);

    logic [LEVELS-1:0] isr_q, isr_d;
    logic [LEVELS-1:0] aeoi_level_q, aeoi_level_d;
    logic [PRIO_W-1:0] prio_rot_q, prio_rot_d;
    logic              rot_aeoi_q, rot_aeoi_d;

    logic [LEVELS-1:0] masked_isr;
    logic [LEVELS-1:0] highest;
    logic [LEVELS-1:0] eoi_clear;
    logic [LEVELS-1:0] aeoi_clear;
    logic [LEVELS-1:0] level_onehot;
    logic              level_ok;

    // Returns the index of the lowest set bit. Normally the input is one-hot.
    function automatic logic [PRIO_W-1:0] lowest_index(input logic [LEVELS-1:0] v);
        logic [PRIO_W-1:0] idx;
        idx = '0;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            if (v[i]) idx = PRIO_W'(i);
        end
        return idx;
    endfunction

    assign masked_isr = special_mask_mode ? (isr_q & ~interrupt_special_mask) : isr_q;

    priority_resolver #(
        .LEVELS (LEVELS),
        .PRIO_W (PRIO_W)
    ) u_resolver (
        .masked  (masked_isr),
        .rotate  (prio_rot_q),
        .highest (highest)
    );

    // Level fields that are out of range can only occur when LEVELS is not a
    // power of two. Those commands are dropped entirely.
    assign level_ok     = 32'(eoi_level) < LEVELS;
    assign level_onehot = level_ok ? (LEVELS'(1) << eoi_level) : '0;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        eoi_clear    = '0;
        aeoi_clear   = '0;
        prio_rot_d   = prio_rot_q;
        rot_aeoi_d   = rot_aeoi_q;
        aeoi_level_d = latch_in_service ? interrupt : aeoi_level_q;

        // Auto-EOI is evaluated first, so a rotation from an OCW2 command in
        // the same cycle replaces the auto-EOI rotation.
        if (end_of_ack && auto_eoi_mode) begin
            aeoi_clear = aeoi_level_q;
            if (rot_aeoi_q && |aeoi_level_q) prio_rot_d = lowest_index(aeoi_level_q);
        end

        if (eoi_valid) begin
            unique case (eoi_cmd)
                EOI_NONSPEC: eoi_clear = highest;
                EOI_SPEC:    eoi_clear = level_onehot;
                EOI_ROT_NONSPEC: begin
                    // An empty masked view leaves the rotation untouched as well.
                    if (|highest) begin
                        eoi_clear  = highest;
                        prio_rot_d = lowest_index(highest);
                    end
                end
                EOI_ROT_SPEC: begin
                    if (level_ok) begin
                        eoi_clear  = level_onehot;
                        prio_rot_d = eoi_level;
                    end
                end
                SET_PRIORITY: begin
                    if (level_ok) prio_rot_d = eoi_level;
                end
                ROT_AEOI_SET: rot_aeoi_d = 1'b1;
                ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
                EOI_NOP:      ;
                default:      ;
            endcase
        end

        // If a set and a clear hit the same bit, the set wins.
        isr_d = (isr_q & ~eoi_clear & ~aeoi_clear) | (latch_in_service ? interrupt : '0);
    end

    // NOTE: non-blocking assignments here, so every flop samples the pre-edge
    // values computed above.
    always_ff @(posedge clock) begin
        if (reset) begin
            isr_q        <= '0;
            aeoi_level_q <= '0;
            prio_rot_q   <= PRIO_W'(LEVELS - 1);
            rot_aeoi_q   <= 1'b0;
        end else begin
            isr_q        <= isr_d;
            aeoi_level_q <= aeoi_level_d;
            prio_rot_q   <= prio_rot_d;
            rot_aeoi_q   <= rot_aeoi_d;
        end
    end

    assign in_service_register      = isr_q;
    assign highest_level_in_service = highest;
    assign priority_rotate          = prio_rot_q;
    assign rotate_in_aeoi           = rot_aeoi_q;

endmodule

// File: tb/tb_in_service_ctrl.sv
// tb_in_service_ctrl: directed vectors with hand-computed expectations.
// Each vector is applied for exactly one clock edge. Its expected outputs are
// pushed into a scoreboard queue. A monitor samples the DUT on the falling
// edge, pops the queue and compares.
module tb_in_service_ctrl;

    localparam int LEVELS = 8;
    localparam int PRIO_W = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              latch_in_service;
    logic [LEVELS-1:0] interrupt;
    logic              end_of_ack;
    logic              auto_eoi_mode;
    logic              eoi_valid;
    logic [2:0]        eoi_cmd;
    logic [PRIO_W-1:0] eoi_level;
    logic              special_mask_mode;
    logic [LEVELS-1:0] interrupt_special_mask;
    logic [LEVELS-1:0] in_service_register;
    logic [LEVELS-1:0] highest_level_in_service;
    logic [PRIO_W-1:0] priority_rotate;
    logic              rotate_in_aeoi;

    typedef struct {
        string             name;
        logic [LEVELS-1:0] isr;
        logic [LEVELS-1:0] hi;
        logic [PRIO_W-1:0] rot;
        logic              raeoi;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    in_service_ctrl #(.LEVELS(LEVELS), .PRIO_W(PRIO_W)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .latch_in_service         (latch_in_service),
        .interrupt                (interrupt),
        .end_of_ack               (end_of_ack),
        .auto_eoi_mode            (auto_eoi_mode),
        .eoi_valid                (eoi_valid),
        .eoi_cmd                  (eoi_cmd),
        .eoi_level                (eoi_level),
        .special_mask_mode        (special_mask_mode),
        .interrupt_special_mask   (interrupt_special_mask),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service),
        .priority_rotate          (priority_rotate),
        .rotate_in_aeoi           (rotate_in_aeoi)
    );

    // Monitor: compares the oldest expectation against the settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (in_service_register !== e.isr || highest_level_in_service !== e.hi ||
                    priority_rotate !== e.rot || rotate_in_aeoi !== e.raeoi) begin
                    n_bad++;
                    $display("FAIL %s: got isr=%h hi=%h rot=%0d raeoi=%b, want isr=%h hi=%h rot=%0d raeoi=%b",
                             e.name, in_service_register, highest_level_in_service,
                             priority_rotate, rotate_in_aeoi, e.isr, e.hi, e.rot, e.raeoi);
                end
            end
        end
    end

    // Queues an expectation and waits until the monitor has consumed it.
    task automatic expect_now(input string nm, input logic [7:0] e_isr, input logic [7:0] e_hi,
                              input logic [2:0] e_rot, input logic e_ra);
        exp_t e;
        e.name = nm; e.isr = e_isr; e.hi = e_hi; e.rot = e_rot; e.raeoi = e_ra;
        sb.push_back(e);
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s: monitor did not consume the vector (queue depth %0d, want 0)", nm, sb.size());
            sb.delete();
        end
    endtask

    // Applies one cycle of strobes, then checks the resulting state.
    task automatic step(input string nm, input logic lat, input logic [7:0] intr, input logic eoa,
                        input logic ev, input logic [2:0] cmd, input logic [2:0] lvl,
                        input logic [7:0] e_isr, input logic [7:0] e_hi,
                        input logic [2:0] e_rot, input logic e_ra);
        latch_in_service = lat;
        interrupt        = intr;
        end_of_ack       = eoa;
        eoi_valid        = ev;
        eoi_cmd          = cmd;
        eoi_level        = lvl;
        @(posedge clock);
        #1;
        latch_in_service = 1'b0;
        interrupt        = '0;
        end_of_ack       = 1'b0;
        eoi_valid        = 1'b0;
        expect_now(nm, e_isr, e_hi, e_rot, e_ra);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; latch_in_service = 1'b0; interrupt = '0; end_of_ack = 1'b0;
        auto_eoi_mode = 1'b0; eoi_valid = 1'b0; eoi_cmd = 3'b010; eoi_level = '0;
        special_mask_mode = 1'b0; interrupt_special_mask = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        expect_now("reset", 8'h00, 8'h00, 3'd7, 1'b0);

        //    name             lat intr  eoa ev  cmd     lvl   isr    hi     rot  ra
        step("latch08",        1, 8'h08, 0, 0, 3'b010, 3'd0, 8'h08, 8'h08, 3'd7, 0);
        step("latch02",        1, 8'h02, 0, 0, 3'b010, 3'd0, 8'h0A, 8'h02, 3'd7, 0);
        step("nseoi_1",        0, 8'h00, 0, 1, 3'b001, 3'd0, 8'h08, 8'h08, 3'd7, 0);
        step("nseoi_2",        0, 8'h00, 0, 1, 3'b001, 3'd0, 8'h00, 8'h00, 3'd7, 0);
        step("nseoi_empty",    0, 8'h00, 0, 1, 3'b001, 3'd0, 8'h00, 8'h00, 3'd7, 0);
        step("rot_ns_empty",   0, 8'h00, 0, 1, 3'b101, 3'd0, 8'h00, 8'h00, 3'd7, 0);
        step("latch41",        1, 8'h41, 0, 0, 3'b010, 3'd0, 8'h41, 8'h01, 3'd7, 0);
        step("rot_nseoi",      0, 8'h00, 0, 1, 3'b101, 3'd0, 8'h40, 8'h40, 3'd0, 0);
        step("ir6_over_ir0",   1, 8'h01, 0, 0, 3'b010, 3'd0, 8'h41, 8'h40, 3'd0, 0);
        step("set_prio3",      0, 8'h00, 0, 1, 3'b110, 3'd3, 8'h41, 8'h40, 3'd3, 0);
        step("spec_eoi6",      0, 8'h00, 0, 1, 3'b011, 3'd6, 8'h01, 8'h01, 3'd3, 0);
        step("latch08_rot3",   1, 8'h08, 0, 0, 3'b010, 3'd0, 8'h09, 8'h01, 3'd3, 0);
        step("rot_spec3",      0, 8'h00, 0, 1, 3'b111, 3'd3, 8'h01, 8'h01, 3'd3, 0);
        step("spec_eoi0",      0, 8'h00, 0, 1, 3'b011, 3'd0, 8'h00, 8'h00, 3'd3, 0);
        step("set_prio7",      0, 8'h00, 0, 1, 3'b110, 3'd7, 8'h00, 8'h00, 3'd7, 0);

        // Auto-EOI with rotation
        auto_eoi_mode = 1'b1;
        step("raeoi_set",      0, 8'h00, 0, 1, 3'b100, 3'd0, 8'h00, 8'h00, 3'd7, 1);
        step("aeoi_latch20",   1, 8'h20, 0, 0, 3'b010, 3'd0, 8'h20, 8'h20, 3'd7, 1);
        step("aeoi_eoa",       0, 8'h00, 1, 0, 3'b010, 3'd0, 8'h00, 8'h00, 3'd5, 1);
        step("aeoi_latch10",   1, 8'h10, 0, 0, 3'b010, 3'd0, 8'h10, 8'h10, 3'd5, 1);
        step("eoi_rot_wins",   0, 8'h00, 1, 1, 3'b110, 3'd2, 8'h00, 8'h00, 3'd2, 1);
        step("raeoi_clr",      0, 8'h00, 0, 1, 3'b000, 3'd0, 8'h00, 8'h00, 3'd2, 0);
        auto_eoi_mode = 1'b0;
        step("set_prio7b",     0, 8'h00, 0, 1, 3'b110, 3'd7, 8'h00, 8'h00, 3'd7, 0);

        // Special mask mode
        special_mask_mode = 1'b1;
        interrupt_special_mask = 8'h02;
        step("smm_latch06",    1, 8'h06, 0, 0, 3'b010, 3'd0, 8'h06, 8'h04, 3'd7, 0);
        step("smm_nseoi",      0, 8'h00, 0, 1, 3'b001, 3'd0, 8'h02, 8'h00, 3'd7, 0);
        step("set_beats_clr",  1, 8'h04, 0, 1, 3'b011, 3'd2, 8'h06, 8'h04, 3'd7, 0);

        // Reset takes priority over a latch strobe in the same cycle
        reset = 1'b1;
        step("reset_override", 1, 8'h80, 0, 1, 3'b100, 3'd0, 8'h00, 8'h00, 3'd7, 0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/in_service_ctrl.md
# in_service_ctrl

Parametrised, clocked in-service register (ISR) block for the PIC datapath. It latches the acknowledged interrupt level and executes every OCW2 end-of-interrupt and rotation command: non-specific, specific, rotate-on-EOI, set-priority and auto-EOI rotate. It owns the priority rotation state and publishes the highest in-service level for the priority comparator. It sits between the control logic (INTA sequencing, OCW decode) and the interrupt-request priority resolver.

## Interface
- `LEVELS`, 8: number of interrupt levels (2..32).
- `PRIO_W`, `$clog2(LEVELS)`: width of a level index.
- `clock` in 1: system clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `latch_in_service` in 1: pulse on first INTA; sets ISR bits from `interrupt`.
- `interrupt` in LEVELS: acknowledged level, one-hot (zero = no-op).
- `end_of_ack` in 1: pulse on last INTA; triggers auto-EOI when enabled.
- `auto_eoi_mode` in 1: ICW4 AEOI bit.
- `eoi_valid` in 1: one-cycle strobe, OCW2 written.
- `eoi_cmd` in 3: OCW2 {R, SL, EOI}.
- `eoi_level` in PRIO_W: OCW2 L field.
- `special_mask_mode` in 1: OCW3 SMM active.
- `interrupt_special_mask` in LEVELS: IMR bits applied when SMM active.
- `in_service_register` out LEVELS: registered ISR.
- `highest_level_in_service` out LEVELS: one-hot highest-priority unmasked ISR bit, or 0.
- `priority_rotate` out PRIO_W: registered index of the lowest-priority level.
- `rotate_in_aeoi` out 1: registered rotate-in-AEOI flag.

## Operation
- Reset values:
  - ISR = 0.
  - `priority_rotate` = LEVELS-1, so IR0 has highest priority.
  - `rotate_in_aeoi` = 0.
  - `highest_level_in_service` = 0.
- Masked view: `ISR & ~interrupt_special_mask` when SMM is active, else ISR. `highest_level_in_service` resolves the masked view with priority starting at index `priority_rotate+1` (mod LEVELS) and descending cyclically.
- `eoi_cmd` decode, acting only when `eoi_valid` is high:
  - `001` non-specific EOI: clear the `highest_level_in_service` bit.
  - `011` specific EOI: clear bit `eoi_level`.
  - `101` rotate on non-specific EOI: clear as `001`; `priority_rotate` ← index of the cleared bit.
  - `111` rotate on specific EOI: clear bit `eoi_level`; `priority_rotate` ← `eoi_level`.
  - `110` set priority: `priority_rotate` ← `eoi_level`; ISR unchanged.
  - `100` sets `rotate_in_aeoi`; `000` clears it; `010` is a no-op.
- Non-specific commands with an empty masked view change nothing, including rotation.
- Auto-EOI:
  - On `end_of_ack` with `auto_eoi_mode` = 1, clear the ISR bits of the level latched by the most recent `latch_in_service`. An internal LEVELS-wide register holds that level; reset value 0.
  - If `rotate_in_aeoi` is also set, `priority_rotate` ← that level's index.
- ISR next-state: `(ISR & ~eoi_clear & ~aeoi_clear) | (latch_in_service ? interrupt : 0)`. Set wins over a clear of the same bit in the same cycle.
- A multi-hot `interrupt` sets all asserted bits; the AEOI register stores all of them. This is outside the defined protocol.
- An `eoi_level` ≥ LEVELS (non-power-of-2 LEVELS) is ignored entirely.
- EOI and AEOI rotate in the same cycle: the `eoi_cmd` rotation wins.

## Timing
- ISR, `priority_rotate`, `rotate_in_aeoi` and the AEOI level update on the clock edge sampling the strobe. All have 1-cycle latency.
- `highest_level_in_service` is combinational from registered state plus the SMM inputs. It is valid in the cycle after the update.
- EOI decode uses the pre-edge ISR and rotation, so back-to-back `eoi_valid` strobes each act on the result of the previous one.
- `reset` overrides all strobes in the same cycle.

## Structure
- Package `pic_pkg` holds:
  - OCW2 command localparams: `EOI_NONSPEC`, `EOI_SPEC`, `EOI_ROT_NONSPEC`, `EOI_ROT_SPEC`, `SET_PRIORITY`, `ROT_AEOI_SET`, `ROT_AEOI_CLR`, `EOI_NOP`.
  - Functions `rotate_right`, `rotate_left` and `resolve_lowest`, parametrised by LEVELS.
- One sub-module, `priority_resolver` (LEVELS): masked vector plus rotate index → one-hot highest bit. It is shared with the IRR side.

## Test plan
- Reset, then `latch_in_service` with `interrupt`=8'h08 → ISR=8'h08, highest=8'h08, `priority_rotate`=7.
- ISR=8'h0A, `eoi_cmd`=001 → ISR=8'h08; a repeat → ISR=8'h00; a third → no change.
- ISR=8'h41, `eoi_cmd`=101 → ISR=8'h40, `priority_rotate`=0. A latch with `interrupt`=8'h01 then gives highest=8'h40, since IR6 now outranks IR0.
- `eoi_cmd`=110, `eoi_level`=3 → `priority_rotate`=3, ISR unchanged. With ISR=8'h09, highest=8'h01.
- AEOI plus rotate (`100` first), latch with `interrupt`=8'h20, then `end_of_ack` → ISR=8'h00, `priority_rotate`=5.
- SMM on, mask=8'h02, ISR=8'h06 → highest=8'h04; `eoi_cmd`=001 → ISR=8'h02. Latch 8'h04 plus `eoi_cmd`=011 with `eoi_level`=2 in the same cycle → bit 2 stays set.
